// File: rtl/vt_encode.sv
// vt_encode: one-cycle Varshamov-Tenengolts systematic encoder.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   in_valid       - data_in is captured on the rising edge when high
//   data_in[k]     - information word
//   out_valid      - high for one cycle per captured word
//   codeword[n]    - VT codeword, codeword[i-1] is position i
//   good_syndrome  - independent syndrome check of the codeword
module vt_encode #(
    parameter int k            = 5,
    parameter int n            = 10,
    parameter int SYNDROME_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [k-1:0] data_in,
    output logic         out_valid,
    output logic [n-1:0] codeword,
    output logic         good_syndrome
);

    // Parity count; also wide enough for any residue 0..n.
    localparam int P = $clog2(n + 1);

    // Sum width: largest sum is n(n+1)/2, plus a spare bit.
    localparam int SW = $clog2(n * (n + 1) / 2 + 1) + 1;

    localparam logic [SW-1:0] MOD_SW = SW'(n + 1);
    localparam logic [P:0]    MOD_P1 = (P + 1)'(n + 1);
    localparam logic [P-1:0]  TARGET = P'(SYNDROME_VAL);

    // Elaboration-time guards on the parameter ranges.
    if (n < 3) begin : g_bad_n
        $error("vt_encode: n must be at least 3");
    end
    if (k < 1 || k > n - P) begin : g_bad_k
        $error("vt_encode: k out of range for n");
    end
    if (SYNDROME_VAL < 0 || SYNDROME_VAL > n) begin : g_bad_a
        $error("vt_encode: SYNDROME_VAL must be in 0..n");
    end

    // Positions 1, 2, 4, ... carry parity.
    function automatic logic is_parity(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

    logic [n-1:0]  data_bits;
    logic [SW-1:0] data_sum;
    logic [P-1:0]  s_mod;
    logic [P-1:0]  d;
    logic [n-1:0]  cw_next;
    logic [SW-1:0] chk_sum;
    logic [P-1:0]  chk_mod;
    logic          good_next;

    // Scatter data bits onto the non-parity positions in ascending
    // order and accumulate the position weights of the 1 bits.
    // Non-parity positions past the k-th data slot stay 0.
    always_comb begin : place_data
        int di;
        data_bits = '0;
        data_sum  = '0;
        di        = 0;
        for (int i = 1; i <= n; i++) begin
            if (!is_parity(i)) begin
                for (int j = 0; j < k; j++) begin
                    if (j == di && data_in[j]) begin
                        data_bits[i-1] = 1'b1;
                        data_sum       = data_sum + SW'(i);
                    end
                end
                di = di + 1;
            end
        end
    end

    assign s_mod = P'(data_sum % MOD_SW);

    // d = (a - s) mod (n+1). The wrap branch adds n+1 in a P+1 bit
    // space so a + (n+1) cannot overflow before the subtraction.
    always_comb begin : deficit
        if (s_mod > TARGET) begin
            d = P'({1'b0, TARGET} + MOD_P1 - {1'b0, s_mod});
        end else begin
            d = TARGET - s_mod;
        end
    end

    // Bit j of d lands on position 2^j. Since sum(2^j * d[j]) = d,
    // this raises the weighted sum by exactly d.
    always_comb begin : place_parity
        cw_next = data_bits;
        for (int j = 0; j < P; j++) begin
            cw_next[(1 << j) - 1] = d[j];
        end
    end

    // Independent re-summation over every position of the word.
    always_comb begin : resum
        chk_sum = '0;
        for (int i = 1; i <= n; i++) begin
            if (cw_next[i-1]) begin
                chk_sum = chk_sum + SW'(i);
            end
        end
    end

    assign chk_mod   = P'(chk_sum % MOD_SW);
    assign good_next = (chk_mod == TARGET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Result registers only move on accepted input; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            codeword      <= '0;
            good_syndrome <= 1'b0;
        end else if (in_valid) begin
            codeword      <= cw_next;
            good_syndrome <= good_next;
        end
    end

endmodule

// File: tb/tb_vt_encode.sv
// tb_vt_encode: randomized and directed checks of vt_encode
// against a behavioural VT model (a=0 and a=5 instances).
module tb_vt_encode;

    localparam int K = 5;
    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [K-1:0] data_in;

    logic         ov0, good0;
    logic [N-1:0] cw0;
    logic         ov5, good5;
    logic [N-1:0] cw5;

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0] exp_cw0, exp_cw5;
    logic         exp_ov, exp_good;

    always #5 clk = ~clk;

    vt_encode #(.k(K), .n(N), .SYNDROME_VAL(0)) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .data_in      (data_in),
        .out_valid    (ov0),
        .codeword     (cw0),
        .good_syndrome(good0)
    );

    vt_encode #(.k(K), .n(N), .SYNDROME_VAL(5)) u_dut5 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .data_in      (data_in),
        .out_valid    (ov5),
        .codeword     (cw5),
        .good_syndrome(good5)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder built straight from the VT definition.
    function automatic logic [N-1:0] model(input logic [K-1:0] din,
                                           input int a);
        int pos[$];
        int m;
        int s;
        int d;
        logic [N-1:0] cw;
        m  = N + 1;
        s  = 0;
        cw = '0;
        for (int i = 1; i <= N; i++) begin
            bit par;
            par = 0;
            for (int b = 0; (1 << b) <= N; b++)
                if ((1 << b) == i) par = 1;
            if (!par) pos.push_back(i);
        end
        for (int j = 0; j < K; j++) begin
            if (din[j]) begin
                cw[pos[j]-1] = 1'b1;
                s += pos[j];
            end
        end
        d = ((a - s) % m + m) % m;
        for (int b = 0; (1 << b) <= N; b++)
            if (((d >> b) & 1) != 0) cw[(1 << b) - 1] = 1'b1;
        return cw;
    endfunction

    function automatic int syndrome(input logic [N-1:0] cw);
        int s;
        s = 0;
        for (int i = 1; i <= N; i++)
            if (cw[i-1]) s += i;
        return s % (N + 1);
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_ov0"}, ov0, exp_ov);
        check({tag, "_cw0"}, cw0, exp_cw0);
        check({tag, "_good0"}, good0, exp_good);
        check({tag, "_ov5"}, ov5, exp_ov);
        check({tag, "_cw5"}, cw5, exp_cw5);
        check({tag, "_good5"}, good5, exp_good);
    endtask

    // Drive one cycle, sample 1 time unit after the edge.
    task automatic step(input string tag, input logic v,
                        input logic [K-1:0] d);
        in_valid = v;
        data_in  = d;
        @(posedge clk);
        #1;
        if (v) begin
            exp_cw0  = model(d, 0);
            exp_cw5  = model(d, 5);
            exp_good = 1'b1;
            exp_ov   = 1'b1;
        end else begin
            exp_ov = 1'b0;
        end
        check_all(tag);
    endtask

    task automatic clear_exp();
        exp_cw0  = '0;
        exp_cw5  = '0;
        exp_good = 1'b0;
        exp_ov   = 1'b0;
    endtask

    initial begin
        logic [K-1:0] r;
        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        clear_exp();
        #12;
        check_all("reset");

        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with literal expected words.
        step("d11011", 1'b1, 5'b11011);
        check("vec_1d5", cw0, 10'h1D5);
        step("d00000", 1'b1, 5'b00000);
        check("vec_000", cw0, 10'h000);
        check("vec_a5_009", cw5, 10'h009);
        step("d11111", 1'b1, 5'b11111);
        check("vec_177", cw0, 10'h177);

        // Idle cycles hold the last word, out_valid drops.
        step("idle", 1'b0, 5'b10101);
        check("idle_hold", cw0, 10'h177);

        // All 32 words back-to-back.
        for (int v = 0; v < 32; v++) begin
            step("stream", 1'b1, K'(v));
            check("stream_syn0", syndrome(cw0), 0);
            check("stream_syn5", syndrome(cw5), 5);
        end

        // Random valid/data mix.
        for (int t = 0; t < 300; t++) begin
            r = K'($urandom);
            step("rand", ($urandom_range(0, 3) != 0), r);
        end

        // Async reset mid-stream, with in_valid held high.
        in_valid = 1'b1;
        data_in  = K'($urandom);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        clear_exp();
        check_all("rst_async");
        data_in = 5'b11011;
        @(posedge clk);
        #1;
        check_all("rst_hold");
        #2;
        rst = 1'b0;
        step("post_rst_idle", 1'b0, 5'b11111);
        step("post_rst_go", 1'b1, 5'b11011);
        check("post_rst_1d5", cw0, 10'h1D5);

        // Reset again; first edge after release must encode.
        #2;
        rst = 1'b1;
        #1;
        clear_exp();
        check_all("rst2");
        #2;
        rst = 1'b0;
        step("rst2_first", 1'b1, 5'b11111);
        check("rst2_177", cw0, 10'h177);

        for (int t = 0; t < 50; t++) begin
            r = K'($urandom);
            step("tail", 1'b1, r);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
